// File: rtl/prefetch_byte_queue.sv
// prefetch_byte_queue
// Instruction prefetch byte queue for the v30mz bus/execution interface.
// Takes 16-bit words (or a single high byte when the prefetch pointer is
// odd) from the bus and hands out one opcode byte per pop. It also tracks
// the prefetch pointer (PFP).
// Optional build macro: PREFETCH_PEEK2_EN adds a second read port
// (data_out_next), a two-byte-available flag (valid2) and a two-byte pop
// (pop2).
module prefetch_byte_queue #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [15:0]                pc,
    input  logic                       push,
    input  logic [15:0]                data_in,
    input  logic                       pop,
    output logic [15:0]                pfp,
    output logic [7:0]                 data_out,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PREFETCH_PEEK2_EN
    ,
    input  logic                       pop2,
    output logic [7:0]                 data_out_next,
    output logic                       valid2
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Pointer add modulo DEPTH; DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] p,
                                              input logic [1:0]    n);
        logic [AW:0] s;
        s = {1'b0, p} + (AW+1)'(n);
        if (s >= (AW+1)'(DEPTH)) begin
            s = s - (AW+1)'(DEPTH);
        end
        return s[AW-1:0];
    endfunction

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW-1:0] tail_p1;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   pfp_q, pfp_d;
    logic [7:0]    mem_w [DEPTH];

    logic          empty_w;
    logic          full_w;
    logic          push_ok;
    logic [1:0]    push_n;
    logic [1:0]    pop_n;

    // Status flags come purely from the registered count.
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q > CW'(DEPTH - 2));

    // A push needs room for a whole word even when only one byte lands.
    // An odd PFP takes only the high byte, which realigns the stream.
    assign push_ok = push && !full_w && !flush;
    assign push_n  = push_ok ? (pfp_q[0] ? 2'd1 : 2'd2) : 2'd0;
    assign tail_p1 = ptr_add(tail_q, 2'd1);

`ifdef PREFETCH_PEEK2_EN
    logic valid2_w;
    assign valid2_w = (count_q >= CW'(2));

    // Pop byte count; pop2 takes precedence over pop when both are asserted.
    always_comb begin
        pop_n = 2'd0;
        if (!flush) begin
            if (pop2) begin
                pop_n = valid2_w ? 2'd2 : 2'd0;
            end else if (pop && !empty_w) begin
                pop_n = 2'd1;
            end
        end
    end
`else
    // Pop byte count: at most one byte per cycle.
    always_comb begin
        pop_n = 2'd0;
        if (!flush && pop && !empty_w) begin
            pop_n = 2'd1;
        end
    end
`endif

    // Next-state arithmetic. Push and pop combine; the write uses the old
    // tail and the read uses the old head.
    always_comb begin
        head_d  = ptr_add(head_q, pop_n);
        tail_d  = ptr_add(tail_q, push_n);
        count_d = count_q + CW'(push_n) - CW'(pop_n);
        pfp_d   = pfp_q + {14'd0, push_n};
    end

    // Pointer, count and PFP registers. Reset beats flush, and flush beats
    // any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pfp_q   <= 16'h0000;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pfp_q   <= pc;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pfp_q   <= pfp_d;
        end
    end

    // Byte storage: one register per slot with its own write enables. The low
    // write lands at tail and the high write at tail+1. They can never hit
    // the same slot in one cycle.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [7:0] byte_q;
            logic       we_lo;
            logic       we_hi;

            assign we_lo = !reset && push_ok && (tail_q == AW'(gi));
            assign we_hi = !reset && push_ok && !pfp_q[0] && (tail_p1 == AW'(gi));

            // Capture the byte aimed at this slot by the current fetch.
            always_ff @(posedge clk) begin
                if (we_lo) begin
                    byte_q <= pfp_q[0] ? data_in[15:8] : data_in[7:0];
                end else if (we_hi) begin
                    byte_q <= data_in[15:8];
                end
            end

            assign mem_w[gi] = byte_q;
        end
    endgenerate

    assign pfp      = pfp_q;
    assign data_out = mem_w[head_q];
    assign empty    = empty_w;
    assign full     = full_w;
    assign count    = count_q;

`ifdef PREFETCH_PEEK2_EN
    assign data_out_next = mem_w[ptr_add(head_q, 2'd1)];
    assign valid2        = valid2_w;
`endif

endmodule

// File: tb/tb_prefetch_byte_queue.sv
// Testbench for prefetch_byte_queue. It uses a byte-queue reference model
// with a scoreboard. The driver applies directed and random cycles and queues
// the expected state and popped bytes. A monitor compares them on the falling
// edge.
module tb_prefetch_byte_queue;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic [15:0]   pc = 16'h0000;
    logic          push = 1'b0;
    logic [15:0]   data_in = 16'h0000;
    logic          pop = 1'b0;
    logic          pop2 = 1'b0;
    logic [15:0]   pfp;
    logic [7:0]    data_out;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
`ifdef PREFETCH_PEEK2_EN
    logic [7:0]    data_out_next;
    logic          valid2;
`endif

    prefetch_byte_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .pc           (pc),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .pfp          (pfp),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .count        (count)
`ifdef PREFETCH_PEEK2_EN
        ,
        .pop2         (pop2),
        .data_out_next(data_out_next),
        .valid2       (valid2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  cnt;
        logic [15:0] pfp;
        logic        emp;
        logic        ful;
        logic        v2;
    } st_t;

    // Reference model: the bytes held, in order, plus the prefetch pointer.
    logic [7:0]  mq[$];
    logic [15:0] pfp_m = 16'h0000;
    // Scoreboard: expected states after each edge and expected pop results.
    st_t         st_q[$];
    logic [16:0] exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic st_t model_state();
        st_t s;
        s.cnt = 8'(mq.size());
        s.pfp = pfp_m;
        s.emp = (mq.size() == 0);
        s.ful = (mq.size() > DEPTH - 2);
        s.v2  = (mq.size() >= 2);
        return s;
    endfunction

    // One clock of stimulus. It records the expected pop data from the
    // pre-edge model, then advances the model after the edge.
    task automatic drive(input logic r, input logic f, input logic [15:0] p,
                         input logic pu, input logic [15:0] d,
                         input logic po, input logic po2_in);
        logic po2;
        logic was_full;
        po2 = po2_in;
`ifndef PREFETCH_PEEK2_EN
        po2 = 1'b0;
`endif
        reset = r; flush = f; pc = p; push = pu; data_in = d; pop = po; pop2 = po2;
        if (!r && !f) begin
            if (po2) begin
                if (mq.size() >= 2) exp_q.push_back({1'b1, mq[1], mq[0]});
            end else if (po && mq.size() >= 1) begin
                exp_q.push_back({1'b0, 8'h00, mq[0]});
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            pfp_m = 16'h0000;
        end else if (f) begin
            mq.delete();
            pfp_m = p;
        end else begin
            was_full = (mq.size() > DEPTH - 2);
            if (po2) begin
                if (mq.size() >= 2) begin
                    void'(mq.pop_front());
                    void'(mq.pop_front());
                end
            end else if (po && mq.size() > 0) begin
                void'(mq.pop_front());
            end
            if (pu && !was_full) begin
                if (pfp_m[0]) begin
                    mq.push_back(d[15:8]);
                    pfp_m = pfp_m + 16'd1;
                end else begin
                    mq.push_back(d[7:0]);
                    mq.push_back(d[15:8]);
                    pfp_m = pfp_m + 16'd2;
                end
            end
        end
        st_q.push_back(model_state());
    endtask

    // Monitor: compares state and, on each accepted pop, the presented bytes.
    initial begin
        st_t         s;
        logic [16:0] e;
        logic        took2;
        forever begin
            @(negedge clk);
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                check("count", 32'(count), 32'(s.cnt));
                check("pfp",   32'(pfp),   32'(s.pfp));
                check("empty", 32'(empty), 32'(s.emp));
                check("full",  32'(full),  32'(s.ful));
`ifdef PREFETCH_PEEK2_EN
                check("valid2", 32'(valid2), 32'(s.v2));
`endif
            end
            took2 = 1'b0;
`ifdef PREFETCH_PEEK2_EN
            took2 = pop2 && valid2;
`endif
            if (!reset && !flush && (took2 || (!pop2 && pop && !empty))) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("pop_width", 32'(took2), 32'(e[16]));
                    check("data_out", 32'(data_out), 32'(e[7:0]));
`ifdef PREFETCH_PEEK2_EN
                    if (took2) check("data_out_next", 32'(data_out_next), 32'(e[15:8]));
`endif
                end
            end
        end
    end

    initial begin
        int mode;
        int fl;
        logic [15:0] npc;
        // Reset
        drive(1, 0, 16'h0, 0, 16'h0, 0, 0);
        drive(1, 0, 16'h0, 0, 16'h0, 0, 0);
        // Even restart, one word, two pops
        drive(0, 1, 16'h0100, 0, 16'h0, 0, 0);
        drive(0, 0, 16'h0, 1, 16'hBBAA, 0, 0);
        drive(0, 0, 16'h0, 0, 16'h0, 1, 0);
        drive(0, 0, 16'h0, 0, 16'h0, 1, 0);
        drive(0, 0, 16'h0, 0, 16'h0, 0, 0);
        // Odd restart realigns
        drive(0, 1, 16'h0011, 0, 16'h0, 0, 0);
        drive(0, 0, 16'h0, 1, 16'h3412, 0, 0);
        drive(0, 0, 16'h0, 1, 16'h7856, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 16'h0, 0, 16'h0, 1, 0);
        // Fill to full, push while full, drain
        drive(0, 1, 16'h0000, 0, 16'h0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 16'h0, 1, 16'(16'h1110 * (i + 1)), 0, 0);
        for (int i = 0; i < 8; i++) drive(0, 0, 16'h0, 0, 16'h0, 1, 0);
        // Simultaneous push and pop at count 4 across the tail wrap
        drive(0, 1, 16'h0200, 0, 16'h0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 16'h0, 1, 16'(16'hA1B2 + i), 0, 0);
        drive(0, 0, 16'h0, 0, 16'h0, 1, 0);
        drive(0, 0, 16'h0, 0, 16'h0, 1, 0);
        drive(0, 0, 16'h0, 1, 16'hC3D4, 1, 0);
        drive(0, 0, 16'h0, 1, 16'hE5F6, 0, 0);
        for (int i = 0; i < 7; i++) drive(0, 0, 16'h0, 0, 16'h0, 1, 0);
        // Flush wins over push/pop; PFP wraps FFFF -> 0000
        drive(0, 0, 16'h0, 1, 16'h1357, 0, 0);
        drive(0, 1, 16'hFFFF, 1, 16'h2468, 1, 0);
        drive(0, 0, 16'h0, 1, 16'hCD12, 0, 0);
        drive(0, 0, 16'h0, 0, 16'h0, 1, 0);
        // PFP wraps FFFE -> 0000
        drive(0, 1, 16'hFFFE, 0, 16'h0, 0, 0);
        drive(0, 0, 16'h0, 1, 16'h9A8B, 0, 0);
        // Reset in the middle of a fetch drops the fetch
        drive(1, 0, 16'h0, 1, 16'hAAAA, 1, 0);
        drive(0, 0, 16'h0, 0, 16'h0, 0, 0);
        // Two-byte pop (plain single pop in the default build)
        drive(0, 1, 16'h0000, 0, 16'h0, 0, 0);
        drive(0, 0, 16'h0, 1, 16'h468B, 0, 0);
        drive(0, 0, 16'h0, 0, 16'h0, 1, 1);
        drive(0, 0, 16'h0, 0, 16'h0, 0, 0);
        // Random traffic in push-heavy / pop-heavy / balanced phases
        for (int i = 0; i < 900; i++) begin
            mode = (i / 40) % 3;
            fl = ($urandom_range(0, 29) == 0);
            npc = 16'($urandom);
            if ($urandom_range(0, 3) == 0) npc[15:4] = 12'hFFF;
            drive(($urandom_range(0, 299) == 0), 1'(fl), npc,
                  ($urandom_range(0, 99) < (mode == 0 ? 80 : (mode == 1 ? 25 : 50))),
                  16'($urandom),
                  ($urandom_range(0, 99) < (mode == 1 ? 80 : (mode == 0 ? 25 : 50))),
                  ($urandom_range(0, 4) == 0));
        end
        drive(0, 0, 16'h0, 0, 16'h0, 0, 0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        check("states_drained", 32'(st_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
